// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: MD op encodings, sequencer defaults, state type and result payload.
// Optional accumulate ops (madd/msub) are enabled with MD_SEQUENCER_MADD_EN.
package mips_pkg;

    localparam int unsigned DATA_W       = 32;
    localparam int unsigned OP_W         = 3;
    localparam int unsigned CNT_W        = 4;
    localparam int unsigned MULT_CYC_DEF = 5;
    localparam int unsigned DIV_CYC_DEF  = 10;

    localparam logic [OP_W-1:0] OP_MULT  = 3'b000;
    localparam logic [OP_W-1:0] OP_MULTU = 3'b001;
    localparam logic [OP_W-1:0] OP_DIV   = 3'b010;
    localparam logic [OP_W-1:0] OP_DIVU  = 3'b011;
    localparam logic [OP_W-1:0] OP_MTHI  = 3'b100;
    localparam logic [OP_W-1:0] OP_MTLO  = 3'b101;
    localparam logic [OP_W-1:0] OP_MADD  = 3'b110;
    localparam logic [OP_W-1:0] OP_MSUB  = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdState_t;

    typedef struct packed {
        logic              div0;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } mdResult_t;

    function automatic logic isDivOp(input logic [OP_W-1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit mult/div result generator for the MD sequencer.
// Accumulate paths (madd/msub) exist only with MD_SEQUENCER_MADD_EN.
module md_arith
    import mips_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] hiCur,
    input  logic [DATA_W-1:0] loCur,
    output logic [DATA_W-1:0] phi,
    output logic [DATA_W-1:0] plo,
    output logic              div0
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    logic signed [PROD_W-1:0] sProd;
    logic        [PROD_W-1:0] uProd;
    logic                     bZero;
    logic        [DATA_W-1:0] divisor;
    logic signed [DATA_W-1:0] sQuo;
    logic signed [DATA_W-1:0] sRem;
    logic        [DATA_W-1:0] uQuo;
    logic        [DATA_W-1:0] uRem;

    // Zero divisor is replaced by 1 so the dividers never see x; the result is discarded via div0.
    assign bZero   = (b == '0);
    assign divisor = bZero ? DATA_W'(1) : b;
    assign div0    = bZero && isDivOp(op);

    assign sProd = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
    assign uProd = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    assign sQuo  = $signed(a) / $signed(divisor);
    assign sRem  = $signed(a) % $signed(divisor);
    assign uQuo  = a / divisor;
    assign uRem  = a % divisor;

`ifdef MD_SEQUENCER_MADD_EN
    logic [PROD_W-1:0] accSum;
    logic [PROD_W-1:0] accDiff;

    assign accSum  = {hiCur, loCur} + $unsigned(sProd);
    assign accDiff = {hiCur, loCur} - $unsigned(sProd);
`else
    logic unusedAcc;

    assign unusedAcc = ^{hiCur, loCur};
`endif

    // Result select: HI is the upper word / remainder, LO the lower word / quotient.
    always_comb begin
        phi = '0;
        plo = '0;
        case (op)
            OP_MULT:  {phi, plo} = $unsigned(sProd);
            OP_MULTU: {phi, plo} = uProd;
            OP_DIV: begin
                phi = $unsigned(sRem);
                plo = $unsigned(sQuo);
            end
            OP_DIVU: begin
                phi = uRem;
                plo = uQuo;
            end
`ifdef MD_SEQUENCER_MADD_EN
            OP_MADD:  {phi, plo} = accSum;
            OP_MSUB:  {phi, plo} = accDiff;
`endif
            default: begin
                phi = '0;
                plo = '0;
            end
        endcase
    end

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer owning HI/LO: times multi-cycle ops and commits results atomically.
// Define MD_SEQUENCER_MADD_EN to enable madd/msub (MDOp 110/111); otherwise they are no-ops.
module md_sequencer
    import mips_pkg::*;
#(
    parameter int unsigned MULT_CYC = MULT_CYC_DEF,
    parameter int unsigned DIV_CYC  = DIV_CYC_DEF
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Start,
    input  logic [OP_W-1:0]   MDOp,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              Flush,
    output logic              Busy,
    output logic [DATA_W-1:0] HI,
    output logic [DATA_W-1:0] LO
);

    mdState_t          state;
    mdState_t          nextState;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cntNext;
    mdResult_t         pend;
    mdResult_t         pendNext;
    mdResult_t         arith;
    logic [DATA_W-1:0] arithHi;
    logic [DATA_W-1:0] arithLo;
    logic              arithDiv0;
    logic [DATA_W-1:0] hiNext;
    logic [DATA_W-1:0] loNext;
    logic              busyNext;
    logic              isLong;

    md_arith uArith (
        .op    (MDOp),
        .a     (A),
        .b     (B),
        .hiCur (HI),
        .loCur (LO),
        .phi   (arithHi),
        .plo   (arithLo),
        .div0  (arithDiv0)
    );

    always_comb begin
        arith      = '0;
        arith.hi   = arithHi;
        arith.lo   = arithLo;
        arith.div0 = arithDiv0;
    end

    // Ops that occupy the sequencer for a latency window.
    always_comb begin
        isLong = 1'b0;
        case (MDOp)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: isLong = 1'b1;
`ifdef MD_SEQUENCER_MADD_EN
            OP_MADD, OP_MSUB:                   isLong = 1'b1;
`endif
            default:                            isLong = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state plus counter, pending result and HI/LO updates.
    always_comb begin
        nextState = state;
        cntNext   = cnt;
        pendNext  = pend;
        hiNext    = HI;
        loNext    = LO;
        case (state)
            IDLE: begin
                if (Start && !Flush) begin
                    if (isLong) begin
                        nextState = RUN;
                        pendNext  = arith;
                        cntNext   = isDivOp(MDOp) ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
                    end else if (MDOp == OP_MTHI) begin
                        hiNext = A;
                    end else if (MDOp == OP_MTLO) begin
                        loNext = A;
                    end
                end
            end
            RUN: begin
                if (Flush) begin
                    nextState = IDLE;
                    cntNext   = '0;
                end else if (cnt == CNT_W'(1)) begin
                    nextState = IDLE;
                    cntNext   = '0;
                    if (!pend.div0) begin
                        hiNext = pend.hi;
                        loNext = pend.lo;
                    end
                end else begin
                    cntNext = cnt - CNT_W'(1);
                end
            end
            default: begin
                nextState = IDLE;
                cntNext   = '0;
            end
        endcase
        busyNext = (nextState == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            pend <= '0;
            HI   <= '0;
            LO   <= '0;
            Busy <= 1'b0;
        end else begin
            cnt  <= cntNext;
            pend <= pendNext;
            HI   <= hiNext;
            LO   <= loNext;
            Busy <= busyNext;
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: vector table through a scoreboard plus flush/reset/overlap corners.
module tb_md_sequencer;
    import mips_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        Start = 1'b0;
    logic        Flush = 1'b0;
    logic [2:0]  MDOp  = '0;
    logic [31:0] A     = '0;
    logic [31:0] B     = '0;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[12];
    logic [31:0] curHi = '0;
    logic [31:0] curLo = '0;

    md_sequencer #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .Start (Start),
        .MDOp  (MDOp),
        .A     (A),
        .B     (B),
        .Flush (Flush),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Called at a negedge: Start is held for exactly one rising edge.
    task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                         input int cyc);
        exp_t e;
        e.name = name;
        e.hi   = hi;
        e.lo   = lo;
        e.cyc  = cyc;
        sb.push_back(e);
        curHi = hi;
        curLo = lo;
        Start = 1'b1;
        MDOp  = op;
        A     = a;
        B     = b;
        @(negedge clk);
        Start = 1'b0;
    endtask

    task automatic waitDone(input int pre);
        int   n;
        exp_t e;
        n = pre;
        while (Busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: got empty queue want entry");
        end else begin
            e = sb.pop_front();
            chk({e.name, ".cycles"}, 32'(n), 32'(e.cyc));
            chk({e.name, ".hi"}, HI, e.hi);
            chk({e.name, ".lo"}, LO, e.lo);
            chk({e.name, ".busy"}, 32'(Busy), 32'(0));
        end
    endtask

    initial begin
        vecs[0]  = '{OP_MULT,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        vecs[1]  = '{OP_DIVU,  32'd7,        32'd2,        32'h00000001, 32'h00000003, 10};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{OP_MTHI,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFD, 0};
        vecs[4]  = '{OP_DIV,   32'd5,        32'd0,        32'h00001234, 32'hFFFFFFFD, 10};
        vecs[5]  = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
        vecs[6]  = '{OP_MTLO,  32'h0000000A, 32'd0,        32'h00000001, 32'h0000000A, 0};
        vecs[7]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
        vecs[8]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[9]  = '{OP_DIV,   32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 10};
        vecs[10] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 10};
        vecs[11] = '{OP_MTHI,  32'h00005555, 32'd0,        32'h00005555, 32'h0FFFFFFF, 0};

        // Reset values, both while held and after release.
        repeat (2) @(negedge clk);
        chk("reset.busy", 32'(Busy), 32'(0));
        chk("reset.hi", HI, 32'h0);
        chk("reset.lo", LO, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("released.busy", 32'(Busy), 32'(0));

        // Table: each op starts in the first idle cycle after the previous one, i.e. back-to-back.
        for (int i = 0; i < 12; i++) begin
            issue($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].hi, vecs[i].lo, vecs[i].cyc);
            waitDone(0);
        end

        // Flush during the third busy cycle: no commit, Busy drops at the next edge.
        Start = 1'b1; MDOp = OP_MULT; A = 32'd3; B = 32'd3;
        @(negedge clk);
        Start = 1'b0;
        chk("flush.busy_on", 32'(Busy), 32'(1));
        @(negedge clk);
        @(negedge clk);
        Flush = 1'b1;
        @(negedge clk);
        Flush = 1'b0;
        chk("flush.busy_off", 32'(Busy), 32'(0));
        chk("flush.hi", HI, curHi);
        chk("flush.lo", LO, curLo);
        repeat (6) @(negedge clk);
        chk("flush.late_hi", HI, curHi);
        chk("flush.late_lo", LO, curLo);

        // Flush together with Start in idle suppresses both mthi and a long op.
        Start = 1'b1; Flush = 1'b1; MDOp = OP_MTHI; A = 32'hDEADBEEF;
        @(negedge clk);
        MDOp = OP_MULT; A = 32'd7; B = 32'd7;
        @(negedge clk);
        Start = 1'b0; Flush = 1'b0;
        chk("flushstart.hi", HI, curHi);
        chk("flushstart.busy", 32'(Busy), 32'(0));
        @(negedge clk);
        chk("flushstart.busy2", 32'(Busy), 32'(0));

        // Start (mthi) while running is ignored and adds no busy cycles.
        issue("overlap", OP_MULT, 32'd2, 32'd3, 32'h0, 32'h6, 5);
        chk("overlap.busy_on", 32'(Busy), 32'(1));
        Start = 1'b1; MDOp = OP_MTHI; A = 32'hDEADBEEF;
        @(negedge clk);
        Start = 1'b0;
        waitDone(1);

        // Asynchronous reset mid-operation, then a fresh multu.
        Start = 1'b1; MDOp = OP_MULT; A = 32'd5; B = 32'd5;
        @(negedge clk);
        Start = 1'b0;
        @(negedge clk);
        chk("midreset.busy_before", 32'(Busy), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("midreset.busy", 32'(Busy), 32'(0));
        chk("midreset.hi", HI, 32'h0);
        chk("midreset.lo", LO, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midreset.idle", 32'(Busy), 32'(0));
        issue("postreset", OP_MULTU, 32'd3, 32'd4, 32'h0, 32'd12, 5);
        waitDone(0);

`ifdef MD_SEQUENCER_MADD_EN
        issue("acc.mtlo", OP_MTLO, 32'd10, 32'd0, 32'h0, 32'd10, 0);
        waitDone(0);
        issue("acc.madd", OP_MADD, 32'd3, 32'd4, 32'h0, 32'd22, 5);
        waitDone(0);
        issue("acc.msub", OP_MSUB, 32'd2, 32'd20, 32'hFFFFFFFF, 32'hFFFFFFEE, 5);
        waitDone(0);
`else
        issue("nop.op110", OP_MADD, 32'd3, 32'd4, 32'h0, 32'd12, 0);
        waitDone(0);
        issue("nop.op111", OP_MSUB, 32'd3, 32'd4, 32'h0, 32'd12, 0);
        waitDone(0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multiply/divide sequencer for the pipelined MIPS core. It owns the HI/LO registers and sits in the E stage beside the ALU. It accepts one MD operation per `Start` pulse from the E-stage controller and times multi-cycle mult/div with a latency counter. It drives `Busy`, which the hazard unit uses to stall dependent mult/div/mfhi/mflo/mthi/mtlo instructions in D. HI/LO results are committed atomically at completion.

## Interface
Parameters:
- `MULT_CYC`, default 5: cycles `Busy` stays high for mult/multu (and madd/msub); legal range 1..15.
- `DIV_CYC`, default 10: cycles `Busy` stays high for div/divu; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `Start`  in  1  one-cycle request; qualifies `MDOp`, `A`, `B`.
- `MDOp`  in  3  operation code; encodings are defined in the shared package.
- `A`  in  32  rs operand (forwarded E value).
- `B`  in  32  rt operand (forwarded E value).
- `Flush`  in  1  aborts an in-flight operation (exception or interrupt).
- `Busy`  out  1  an operation is in flight.
- `HI`  out  32  current HI register.
- `LO`  out  32  current LO register.

## Operation
MDOp encodings:
- 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo.
- 110 madd, 111 msub: only with the macro in Configuration; otherwise they are no-ops.

States: IDLE, RUN.
- **Reset:** state IDLE, `Busy`=0, `HI`=0, `LO`=0, counter=0, pending registers=0.
- **IDLE + `Start` + mult/div op:**
  - Compute the 64-bit result combinationally from A/B and latch it into pending registers `phi`/`plo`.
  - Load the counter with `MULT_CYC` or `DIV_CYC`; go to RUN.
- **IDLE + `Start` + mthi/mtlo:**
  - Write A into HI or LO at this edge.
  - No RUN state; `Busy` stays 0.
- **RUN:**
  - Decrement the counter each cycle.
  - When the counter reaches 1, commit `phi`→HI and `plo`→LO at that edge and return to IDLE.
- **Arithmetic:**
  - mult is signed 32x32→64 (HI = upper word, LO = lower word); multu is unsigned.
  - div: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend; divu is unsigned.
- **Divide by zero:** the operation still occupies `DIV_CYC` cycles; HI and LO are left unchanged at commit.
- **`Start` while in RUN:** ignored. The hazard unit guarantees this does not occur; the bench checks it anyway.
- **`Flush` in RUN:** return to IDLE at the next edge. No commit; HI/LO keep their pre-operation values.
- **`Flush` and `Start` in the same cycle:** `Start` is ignored, including mthi/mtlo.
- **Reset during RUN:** immediate return to reset values; the pending result is lost.

## Timing
- `Start` is sampled at edge T.
- For mult/div:
  - `Busy`=1 from T+1 through T+N, where N = the latency parameter.
  - HI/LO take new values at the edge ending cycle T+N, at the same edge where `Busy` falls.
  - An mfhi in D sees the new value in the first cycle `Busy`=0.
- mthi/mtlo: HI/LO are updated at edge T and visible from cycle T+1; `Busy` is never asserted.
- `Busy` is a registered output with no combinational path from `Start`. The hazard unit ORs `StartE` with `Busy` itself.
- Back-to-back: a new `Start` is accepted in the first cycle after `Busy` falls.

## Configuration
- Macro `MD_SEQUENCER_MADD_EN`.
- **Defined:** MDOp 110/111 are madd/msub.
  - Signed product added to / subtracted from {HI,LO}.
  - `phi`/`plo` are computed from the HI/LO values at the `Start` edge.
  - Latency is `MULT_CYC`.
- **Not defined:** 110/111 are accepted as no-ops. No state change, `Busy` stays 0, and no accumulate logic is synthesized.

## Structure
- **Shared package (`mips_pkg`):**
  - MDOp encoding constants.
  - Default `MULT_CYC` and `DIV_CYC`.
  - The state enum (IDLE, RUN).
- **Sub-module `md_arith`:** purely combinational 64-bit result generator. Inputs: op, A, B, HI, LO. Outputs: `phi`, `plo`, and `div0`.
- **Sequencer proper:** FSM, counter, pending registers, and HI/LO.

## Test plan
- Reset, then mult A=0xFFFFFFFF (-1), B=2 → `Busy`=1 for exactly 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFE as `Busy` falls.
- divu A=7, B=2 → `Busy` 10 cycles; LO=3, HI=1. div A=-7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- mthi A=0x1234 → HI=0x1234 the next cycle, `Busy` never high. div by B=0 → HI/LO stay 0x1234 and prior LO after 10 cycles.
- mult in flight, `Flush` at cycle 3 → `Busy` low the next cycle; HI/LO unchanged. A `Start` asserted during RUN → ignored, no extra busy cycles.
- `rst_n` dropped mid-RUN → `Busy`, HI, LO = 0 immediately (asynchronous); a subsequent multu 3×4 → LO=12, HI=0.
- With `MD_SEQUENCER_MADD_EN`: HI=0, LO=10, madd 3×4 → LO=22 after 5 cycles. Without it: op 110 → no change, `Busy`=0.
